// File: rtl/sudoku_pkg.sv
// Shared definitions for the Sudoku generator: grid geometry, the tile
// sequencer state encoding and the default backtrack budget.
package sudoku_pkg;

  localparam int GRID_LEN         = 9;
  localparam int NUM_TILES        = GRID_LEN * GRID_LEN;
  localparam int BT_LIMIT_DEFAULT = 4095;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2,
    FAIL = 2'd3
  } seq_state_t;

endpackage

// File: rtl/tile_sequencer.sv
// Turn-token owner for the tile chain: grants one tile at a time, moves the
// active index forward/back on that tile's response and reports completion,
// exhaustion or a protocol violation. All outputs come straight from flops.
module tile_sequencer #(
  parameter int NUM_TILES = sudoku_pkg::NUM_TILES,
  parameter int BT_LIMIT  = sudoku_pkg::BT_LIMIT_DEFAULT,
  parameter int BT_W      = $clog2(BT_LIMIT + 1)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic [NUM_TILES-1:0]         passfwd,
  input  logic [NUM_TILES-1:0]         passbak,
  output logic [NUM_TILES-1:0]         myturn,
  output logic [$clog2(NUM_TILES)-1:0] index,
  output logic [BT_W-1:0]              backtracks,
  output logic                         busy,
  output logic                         done,
  output logic                         failed,
  output logic                         protoerr
);
  import sudoku_pkg::*;

  localparam int IDX_W = $clog2(NUM_TILES);

  seq_state_t           state_q, state_d;
  logic [IDX_W-1:0]     index_q, index_d;
  logic [BT_W-1:0]      bt_q, bt_d;
  logic [BT_W-1:0]      bt_inc;
  logic [NUM_TILES-1:0] myturn_q, myturn_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 failed_q, failed_d;
  logic                 proto_q, proto_d;
  logic                 grant_d;

  // Per-tile decode of the active index, used both to qualify responses
  // and to steer the next one-hot grant.
  logic [NUM_TILES-1:0] cur_sel;
  logic                 fwd_hit, bak_hit, stray;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_TILES; gi++) begin : g_tile
      assign cur_sel[gi]  = (index_q == IDX_W'(gi));
      assign myturn_d[gi] = grant_d & (index_d == IDX_W'(gi));
    end
  endgenerate

  assign fwd_hit = |(passfwd & cur_sel);
  assign bak_hit = |(passbak & cur_sel);
  assign stray   = |((passfwd | passbak) & ~cur_sel);
  assign bt_inc  = bt_q + BT_W'(1);

  // Next-state, index/counter update and flag logic for the sequencer FSM.
  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    bt_d     = bt_q;
    done_d   = done_q;
    failed_d = failed_q;
    proto_d  = proto_q;
    grant_d  = 1'b0;

    unique case (state_q)
      WAIT: begin
        if (stray || (fwd_hit && bak_hit)) begin
          state_d  = FAIL;
          failed_d = 1'b1;
          proto_d  = 1'b1;
        end else if (fwd_hit) begin
          if (index_q == IDX_W'(NUM_TILES - 1)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            index_d = index_q + IDX_W'(1);
            grant_d = 1'b1;
          end
        end else if (bak_hit) begin
          if (index_q == '0) begin
            state_d  = FAIL;
            failed_d = 1'b1;
          end else begin
            // Hitting the budget terminates the run, so the counter can
            // never step past BT_LIMIT.
            bt_d = bt_inc;
            if (bt_inc == BT_W'(BT_LIMIT)) begin
              state_d  = FAIL;
              failed_d = 1'b1;
            end else begin
              index_d = index_q - IDX_W'(1);
              grant_d = 1'b1;
            end
          end
        end
      end
      default: begin
        // IDLE, DONE and FAIL all accept a fresh start; pass inputs ignored.
        if (start) begin
          state_d  = WAIT;
          index_d  = '0;
          bt_d     = '0;
          done_d   = 1'b0;
          failed_d = 1'b0;
          proto_d  = 1'b0;
          grant_d  = 1'b1;
        end
      end
    endcase

    busy_d = (state_d == WAIT);
  end

  // State and output registers; reset drops any in-flight grant at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      index_q  <= '0;
      bt_q     <= '0;
      myturn_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      failed_q <= 1'b0;
      proto_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      bt_q     <= bt_d;
      myturn_q <= myturn_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      failed_q <= failed_d;
      proto_q  <= proto_d;
    end
  end

  assign myturn     = myturn_q;
  assign index      = index_q;
  assign backtracks = bt_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign failed     = failed_q;
  assign protoerr   = proto_q;

endmodule

// File: tb/tb_tile_sequencer.sv
// Bench for tile_sequencer with 4 tiles and a backtrack budget of 3:
// directed scenarios followed by random traffic, all checked every cycle
// against a behavioural model of the token-passing rules.
module tb_tile_sequencer;

  localparam int N     = 4;
  localparam int LIMIT = 3;
  localparam int BW    = $clog2(LIMIT + 1);

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [N-1:0]  passfwd = '0;
  logic [N-1:0]  passbak = '0;
  logic [N-1:0]  myturn;
  logic [1:0]    index;
  logic [BW-1:0] backtracks;
  logic          busy, done, failed, protoerr;

  int total = 0;
  int bad   = 0;

  // Model: run phase, active tile, backtrack count, flags, expected grant.
  localparam int M_IDLE = 0, M_RUN = 1, M_END = 2;
  int           m_phase = M_IDLE;
  int           m_idx   = 0;
  int           m_bt    = 0;
  bit           m_done  = 0, m_failed = 0, m_proto = 0;
  logic [N-1:0] m_turn  = '0;

  tile_sequencer #(.NUM_TILES(N), .BT_LIMIT(LIMIT), .BT_W(BW)) dut (
    .clock(clock), .reset(reset), .start(start),
    .passfwd(passfwd), .passbak(passbak),
    .myturn(myturn), .index(index), .backtracks(backtracks),
    .busy(busy), .done(done), .failed(failed), .protoerr(protoerr)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("myturn", 32'(myturn), 32'(m_turn));
    chk("index", 32'(index), 32'(m_idx));
    chk("backtracks", 32'(backtracks), 32'(m_bt));
    chk("busy", 32'(busy), 32'(m_phase == M_RUN));
    chk("done", 32'(done), 32'(m_done));
    chk("failed", 32'(failed), 32'(m_failed));
    chk("protoerr", 32'(protoerr), 32'(m_proto));
  endtask

  // One clock of the token rules, seen from outside.
  task automatic model(input bit s, input logic [N-1:0] f, input logic [N-1:0] b);
    logic [N-1:0] mine;
    m_turn = '0;
    if (m_phase != M_RUN) begin
      if (s) begin
        m_phase = M_RUN; m_idx = 0; m_bt = 0;
        m_done = 0; m_failed = 0; m_proto = 0;
        m_turn = 4'b0001;
      end
    end else begin
      mine = 4'b0001 << m_idx;
      if ((((f | b) & ~mine) != 0) || (f[m_idx] && b[m_idx])) begin
        m_phase = M_END; m_failed = 1; m_proto = 1;
      end else if (f[m_idx]) begin
        if (m_idx == N - 1) begin
          m_phase = M_END; m_done = 1;
        end else begin
          m_idx++; m_turn = 4'b0001 << m_idx;
        end
      end else if (b[m_idx]) begin
        if (m_idx == 0) begin
          m_phase = M_END; m_failed = 1;
        end else begin
          m_bt++;
          if (m_bt == LIMIT) begin
            m_phase = M_END; m_failed = 1;
          end else begin
            m_idx--; m_turn = 4'b0001 << m_idx;
          end
        end
      end
    end
  endtask

  task automatic step(input bit s, input logic [N-1:0] f, input logic [N-1:0] b);
    start = s; passfwd = f; passbak = b;
    @(posedge clock);
    model(s, f, b);
    #1;
    start = 1'b0; passfwd = '0; passbak = '0;
    check_all();
    $display("step start=%0b fwd=%b bak=%b -> myturn=%b index=%0d bt=%0d busy=%0b done=%0b failed=%0b proto=%0b",
             s, f, b, myturn, index, backtracks, busy, done, failed, protoerr);
  endtask

  task automatic idle();             step(1'b0, '0, '0);              endtask
  task automatic go();               step(1'b1, '0, '0);              endtask
  task automatic fwd(input int i);   step(1'b0, 4'b0001 << i, '0);    endtask
  task automatic bak(input int i);   step(1'b0, '0, 4'b0001 << i);    endtask

  task automatic async_reset();
    reset = 1'b1;
    #1;
    chk("rst_myturn", 32'(myturn), 32'd0);
    chk("rst_index", 32'(index), 32'd0);
    chk("rst_bt", 32'(backtracks), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_flags", 32'({done, failed, protoerr}), 32'd0);
    m_phase = M_IDLE; m_idx = 0; m_bt = 0;
    m_done = 0; m_failed = 0; m_proto = 0; m_turn = '0;
    $display("async reset -> myturn=%b index=%0d busy=%0b", myturn, index, busy);
    @(posedge clock);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    int r;
    logic [N-1:0] rf, rb;

    // Power-up reset.
    async_reset();
    idle();

    // 1: clean forward run, each grant answered one cycle later.
    go();
    for (int i = 0; i < N; i++) begin
      idle();
      fwd(i);
    end
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_index", 32'(index), 32'd3);

    // 2: single backtrack then completion; a start from DONE also restarts.
    go();
    chk("t2_done_cleared", 32'(done), 32'd0);
    fwd(0); fwd(1); bak(2);
    chk("t2_turn", 32'(myturn), 32'b0010);
    chk("t2_bt", 32'(backtracks), 32'd1);
    fwd(1); fwd(2); fwd(3);
    chk("t2_done", 32'(done), 32'd1);

    // 3: backtrack from tile 0.
    go(); idle(); bak(0);
    chk("t3_failed", 32'(failed), 32'd1);
    chk("t3_proto", 32'(protoerr), 32'd0);
    idle();

    // 4: budget exhaustion, final grant suppressed.
    go();
    for (int k = 0; k < LIMIT; k++) begin
      fwd(0); bak(1);
    end
    chk("t4_failed", 32'(failed), 32'd1);
    chk("t4_bt", 32'(backtracks), 32'd3);
    chk("t4_turn", 32'(myturn), 32'd0);

    // 5: protocol errors; pass inputs afterwards are ignored.
    go(); fwd(0); fwd(2);
    chk("t5a_proto", 32'(protoerr), 32'd1);
    fwd(1); bak(1);
    go(); fwd(0); step(1'b0, 4'b0010, 4'b0010);
    chk("t5b_proto", 32'(protoerr), 32'd1);

    // 6: reset mid-run, no grant on release, then a clean restart.
    go(); fwd(0); fwd(1);
    step(1'b1, '0, '0);       // start in WAIT is ignored
    async_reset();
    idle();
    go();
    chk("t6_turn", 32'(myturn), 32'b0001);
    fwd(0); fwd(1); fwd(2); fwd(3);

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      r = $urandom_range(0, 99);
      if (m_phase != M_RUN) begin
        rf = 4'($urandom); rb = 4'($urandom);
        step(r < 50, (r % 3 == 0) ? rf : '0, (r % 5 == 0) ? rb : '0);
      end else if (r < 45) begin
        fwd(m_idx);
      end else if (r < 68) begin
        bak(m_idx);
      end else if (r < 88) begin
        step(r < 72, '0, '0);
      end else if (r < 95) begin
        rf = 4'b0001 << ((m_idx + $urandom_range(1, N - 1)) % N);
        if (r < 92) step(1'b0, rf, '0);
        else step(1'b0, '0, rf);
      end else if (r < 98) begin
        step(1'b0, 4'b0001 << m_idx, 4'b0001 << m_idx);
      end else begin
        async_reset();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
